// File: rtl/generic_fifo_rd_stage.sv
// generic_fifo_rd_stage
// Turns a FIFO controller's pop strobe plus a register file with one clock of
// read latency into a valid/ready stream. A 2-entry in-order buffer absorbs
// the words that are still arriving after downstream stalls. Reads are only
// issued while that buffer has room for them.
//
// Ports:
//   clk          single clock, rising edge
//   reset_n      asynchronous active-low reset
//   sreset_n     synchronous active-low flush; cancels any read in flight
//   fifo_empty   empty flag from the upstream FIFO controller
//   fifo_rd_op   pop strobe / register-file read enable (combinational)
//   fifo_rd_data register-file read data, valid one clk after fifo_rd_op
//   out_valid    a word is presented downstream
//   out_data     presented word (registered buffer head)
//   out_ready    downstream accept
//   busy         stage holds a word or has a read in flight
module generic_fifo_rd_stage #(
    parameter int DAT_WIDTH = 36
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sreset_n,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_op,
    input  logic [DAT_WIDTH-1:0] fifo_rd_data,
    output logic                 out_valid,
    output logic [DAT_WIDTH-1:0] out_data,
    input  logic                 out_ready,
    output logic                 busy
);

    logic [1:0]           occ;      // buffered words, 0..2
    logic                 infl;     // read issued on the previous clk
    logic [DAT_WIDTH-1:0] head;
    logic [DAT_WIDTH-1:0] tail;

    logic       pop;
    logic       cap;
    logic [2:0] committed;
    logic [1:0] occ_nxt;
    logic       wr_idx;

    assign pop = out_valid & out_ready;

    // A returning word is dropped while the stage is being flushed.
    assign cap = infl & sreset_n;

    // Words already held plus the one still on its way from the register file.
    assign committed = {1'b0, occ} + {2'b00, infl};

    // A pop on this clk frees a slot, so the stage can refill back-to-back at
    // full rate. reset_n gates the strobe so it drops without a clock edge.
    assign fifo_rd_op = reset_n & sreset_n & ~fifo_empty &
                        ((committed < 3'd2) | pop);

    assign occ_nxt = occ + {1'b0, infl} - {1'b0, pop};

    // Slot that the captured word lands in after this clk's pop has been
    // applied: the head when the buffer drains to empty, otherwise the tail.
    assign wr_idx = (occ_nxt == 2'd2);

    assign out_valid = (occ != 2'd0);
    assign out_data  = head;
    assign busy      = (occ != 2'd0) | infl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ  <= 2'd0;
            infl <= 1'b0;
            head <= '0;
            tail <= '0;
        end else if (!sreset_n) begin
            occ  <= 2'd0;
            infl <= 1'b0;
        end else begin
            infl <= fifo_rd_op;
            occ  <= occ_nxt;
            // Pop shifts the second entry forward; a same-clk capture below
            // overrides the head when the buffer held only one word.
            if (pop)
                head <= tail;
            if (cap) begin
                if (wr_idx)
                    tail <= fifo_rd_data;
                else
                    head <= fifo_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_generic_fifo_rd_stage.sv
module tb_generic_fifo_rd_stage;

    localparam int W = 36;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         sreset_n;
    logic         fifo_empty;
    logic         fifo_rd_op;
    logic [W-1:0] fifo_rd_data;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         busy;

    always #5 clk = ~clk;

    generic_fifo_rd_stage #(.DAT_WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sreset_n     (sreset_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_op   (fifo_rd_op),
        .fifo_rd_data (fifo_rd_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    // Input source: hand-driven table values, or the upstream FIFO model.
    logic         use_model;
    logic         t_empty;
    logic [W-1:0] t_rdata;

    // Upstream FIFO model: empty flag follows the pointers, which move on the
    // clk where a push/pop is sampled; read data returns one clk after the pop.
    logic [W-1:0] mem [0:2047];
    int           wptr, rptr;
    logic         m_empty;
    logic [W-1:0] m_rdata;
    logic         m_err;
    logic         wr_en;
    logic [W-1:0] wr_data;

    assign m_empty      = (wptr == rptr);
    assign fifo_empty   = use_model ? m_empty : t_empty;
    assign fifo_rd_data = use_model ? m_rdata : t_rdata;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rptr <= wptr;
            if (wr_en) begin
                mem[wptr % 2048] <= wr_data;
                wptr <= wptr + 1;
            end
        end else begin
            if (wr_en) begin
                mem[wptr % 2048] <= wr_data;
                wptr <= wptr + 1;
            end
            if (use_model && fifo_rd_op) begin
                if (m_empty) m_err <= 1'b1;
                m_rdata <= mem[rptr % 2048];
                rptr    <= rptr + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Per-phase bookkeeping for the model-driven sequences.
    logic [W-1:0] sb[$];
    int           acc_cyc[$];
    int           cyc, rd_cnt, acc_cnt, first_rd;

    task automatic clear_counts();
        cyc = 0; rd_cnt = 0; acc_cnt = 0; first_rd = -1;
        acc_cyc.delete();
    endtask

    // One clock of streaming: drive out_ready, sample, score.
    task automatic step(input logic rdy);
        @(negedge clk);
        wr_en     = 1'b0;
        sreset_n  = 1'b1;
        out_ready = rdy;
        #1;
        cyc++;
        chk("outstanding_le2", 64'((rd_cnt - acc_cnt) <= 2), 64'd1);
        chk("rd_while_empty", {63'd0, fifo_rd_op & fifo_empty}, 64'd0);
        if (fifo_rd_op) begin
            if (first_rd < 0) first_rd = cyc;
            rd_cnt++;
        end
        if (out_valid && rdy) begin
            chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) chk("order", 64'(out_data), 64'(sb.pop_front()));
            acc_cyc.push_back(cyc);
            acc_cnt++;
        end
    endtask

    // Fill the FIFO model while the stage is held in flush.
    task automatic preload(input int n, input int base, input bit rnd);
        sreset_n  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = rnd ? W'({$urandom, $urandom}) : W'(base + i);
            sb.push_back(wr_data);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    typedef struct {
        logic         srst, empty, rdy;
        logic [W-1:0] rdata;
        logic         e_rd, e_vld, e_busy;
        logic [W-1:0] e_data;
    } vec_t;

    function automatic vec_t mk(input logic s, e, r, input logic [W-1:0] d,
                                input logic erd, ev, eb, input logic [W-1:0] ed);
        vec_t v;
        v.srst = s; v.empty = e; v.rdy = r; v.rdata = d;
        v.e_rd = erd; v.e_vld = ev; v.e_busy = eb; v.e_data = ed;
        return v;
    endfunction

    initial begin
        vec_t tv[18];
        int   r0;
        // srst empty rdy rdata | rd_op valid busy data
        tv[0]  = mk(1, 1, 1, 'h00, 0, 0, 0, 'h00);
        tv[1]  = mk(1, 0, 1, 'h00, 1, 0, 0, 'h00);
        tv[2]  = mk(1, 0, 0, 'h11, 1, 0, 1, 'h00);
        tv[3]  = mk(1, 0, 0, 'h22, 0, 1, 1, 'h11);  // committed = 2: no read
        tv[4]  = mk(1, 0, 0, 'h00, 0, 1, 1, 'h11);  // stalled, held
        tv[5]  = mk(1, 0, 1, 'h00, 1, 1, 1, 'h11);  // pop frees a slot
        tv[6]  = mk(1, 1, 1, 'h33, 0, 1, 1, 'h22);  // occ=2 pop: shift
        tv[7]  = mk(1, 1, 0, 'h00, 0, 1, 1, 'h33);  // occ=1 pop+capture
        tv[8]  = mk(1, 1, 1, 'h00, 0, 1, 1, 'h33);
        tv[9]  = mk(1, 1, 0, 'h00, 0, 0, 0, 'h00);
        tv[10] = mk(1, 0, 0, 'h00, 1, 0, 0, 'h00);
        tv[11] = mk(1, 0, 0, 'h44, 1, 0, 1, 'h00);
        tv[12] = mk(0, 0, 0, 'h55, 0, 1, 1, 'h44);  // flush: occ=1, infl=1
        tv[13] = mk(1, 1, 0, 'h66, 0, 0, 0, 'h00);  // 0x55 discarded
        tv[14] = mk(1, 0, 1, 'h00, 1, 0, 0, 'h00);
        tv[15] = mk(1, 1, 1, 'h77, 0, 0, 1, 'h00);
        tv[16] = mk(1, 1, 1, 'h00, 0, 1, 1, 'h77);
        tv[17] = mk(1, 1, 1, 'h00, 0, 0, 0, 'h00);

        use_model = 1'b0; t_empty = 1'b0; t_rdata = '0;
        wptr = 0; rptr = 0; m_rdata = '0; m_err = 1'b0;
        wr_en = 1'b0; wr_data = '0;
        sreset_n = 1'b1; out_ready = 1'b1;
        reset_n = 1'b0;
        clear_counts();

        // Reset state, with empty low so rd_op would otherwise be high.
        #12;
        chk("rst_rd_op", 64'(fifo_rd_op), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        t_empty = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            sreset_n  = tv[i].srst;
            t_empty   = tv[i].empty;
            out_ready = tv[i].rdy;
            t_rdata   = tv[i].rdata;
            #1;
            chk($sformatf("v%0d_rd_op", i), 64'(fifo_rd_op), 64'(tv[i].e_rd));
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(tv[i].e_vld));
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'(tv[i].e_busy));
            if (tv[i].e_vld)
                chk($sformatf("v%0d_data", i), 64'(out_data), 64'(tv[i].e_data));
        end

        // Streaming 0x1..0x10 at full rate.
        use_model = 1'b1;
        preload(16, 1, 1'b0);
        clear_counts();
        for (int i = 0; i < 25; i++) step(1'b1);
        chk("stream_rd_ops", 64'(rd_cnt), 64'd16);
        chk("stream_words", 64'(acc_cnt), 64'd16);
        if (acc_cnt == 16) begin
            chk("stream_latency", 64'(acc_cyc[0] - first_rd), 64'd2);
            chk("stream_back2back", 64'(acc_cyc[15] - acc_cyc[0]), 64'd15);
        end

        // Backpressure with 8 queued.
        preload(8, 1, 1'b0);
        clear_counts();
        for (int i = 0; i < 5; i++) step(1'b0);
        chk("bp_rd_ops", 64'(rd_cnt), 64'd2);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_head", 64'(out_data), 64'd1);
        r0 = 0;
        while (acc_cnt < 8 && r0 < 40) begin step(1'b1); r0++; end
        chk("bp_drained", 64'(acc_cnt), 64'd8);

        // Asynchronous reset mid-stream with occ=2.
        preload(4, 'h100, 1'b0);
        clear_counts();
        for (int i = 0; i < 4; i++) step(1'b0);
        chk("ar_pre_valid", 64'(out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_rd_op", 64'(fifo_rd_op), 64'd0);
        chk("ar_data", 64'(out_data), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        sb.delete();

        // Single word 0xA5.
        clear_counts();
        wr_en = 1'b1; wr_data = 'hA5; sb.push_back('hA5);
        for (int i = 0; i < 6; i++) step(1'b1);
        chk("single_rd_ops", 64'(rd_cnt), 64'd1);
        chk("single_words", 64'(acc_cnt), 64'd1);

        // 1000 words with random out_ready.
        preload(1000, 0, 1'b1);
        clear_counts();
        r0 = 0;
        while (acc_cnt < 1000 && r0 < 5000) begin
            step(1'($urandom_range(0, 1)));
            r0++;
        end
        chk("rand_words", 64'(acc_cnt), 64'd1000);
        chk("rand_sb_empty", 64'(sb.size()), 64'd0);
        chk("upstream_err", 64'(m_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/generic_fifo_rd_stage.md
GENERIC_FIFO_RD_STAGE -- requirements
Module: generic_fifo_rd_stage

Interface
REQ-001 Parameter DAT_WIDTH, default 36: data width, equal to the upstream FIFO data width.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 sreset_n  input  1  synchronous active-low clear; flushes the stage.
REQ-005 fifo_empty  input  1  empty flag from the upstream FIFO controller.
REQ-006 fifo_rd_op  output  1  pop strobe to the FIFO controller and register-file read enable.
REQ-007 fifo_rd_data  input  DAT_WIDTH  register-file read data, valid exactly one clk after fifo_rd_op.
REQ-008 out_valid  output  1  a word is presented downstream.
REQ-009 out_data  output  DAT_WIDTH  presented word.
REQ-010 out_ready  input  1  downstream accepts when high together with out_valid.
REQ-011 busy  output  1  high when the stage holds any word or has a read in flight.

Function
REQ-012 The block SHALL convert the FIFO pop/one-cycle-latency read into a valid/ready stream through a 2-entry in-order output buffer.
REQ-013 The block SHALL keep occ (0..2, buffered words) and infl (0..1, read issued last cycle).
REQ-014 The block SHALL define pop = out_valid & out_ready.
REQ-015 The block SHALL drive fifo_rd_op = sreset_n & !fifo_empty & ((occ + infl < 2) | pop), combinationally.
REQ-016 The upstream empty flag deasserts/asserts on the clk after a pop is sampled; the block SHALL never rely on fifo_rd_op being issued while fifo_empty=1.
REQ-017 The block SHALL set infl to fifo_rd_op on each clk.
REQ-018 When infl=1, the block SHALL capture fifo_rd_data into the buffer tail on that clk.
REQ-019 occ next SHALL equal occ + infl - pop, and SHALL never exceed 2 or go below 0.
REQ-020 out_valid SHALL equal (occ != 0).
REQ-021 out_data SHALL be the buffer head.
REQ-022 out_data SHALL be registered, not a combinational path from fifo_rd_data.
REQ-023 With out_valid=1 and out_ready=0, out_valid and out_data SHALL hold stable.
REQ-024 The block SHALL deliver words in FIFO order with no loss or duplication.
REQ-025 Steady-state throughput SHALL be 1 word/clk when the FIFO is non-empty and out_ready=1.
REQ-026 First-word latency SHALL be 2 clks from fifo_empty falling: rd_op in cycle t, out_valid in cycle t+2.
REQ-027 When capture and pop occur on the same clk with occ=1, the head SHALL be replaced by the captured word.
REQ-028 When capture and pop occur on the same clk with occ=2, the second entry SHALL shift to the head and the captured word SHALL go to the second slot.
REQ-029 busy SHALL equal (occ != 0) | infl.

Reset
REQ-030 With reset_n=0, the block SHALL asynchronously force occ=0, infl=0, out_valid=0, busy=0, fifo_rd_op=0 and out_data=0.
REQ-031 With sreset_n=0 at a clk, the block SHALL clear occ and infl.
REQ-032 With sreset_n=0 at a clk, the block SHALL discard any word returning from an in-flight read.
REQ-033 With sreset_n=0 at a clk, the block SHALL keep fifo_rd_op=0.
REQ-034 On the clk after sreset_n returns high, the block SHALL resume normal operation.
REQ-035 The upstream FIFO is not cleared by this block.

Verification
REQ-036 Reset: reset_n low mid-stream with occ=2 -> out_valid, busy and fifo_rd_op are 0 immediately, with no clk edge needed.
REQ-037 Streaming: FIFO preloaded with 0x1..0x10, out_ready=1 -> out_data 0x1..0x10 on 16 consecutive clks, first at 2 clks after the first fifo_rd_op, exactly 16 fifo_rd_op pulses.
REQ-038 Backpressure: out_ready=0 for 5 clks with 8 words queued -> exactly 2 rd_op issued, occ=2, out_data held at 0x1; out_ready=1 -> 0x1,0x2,... in order, none lost.
REQ-039 Single entry: one word 0xA5 written, out_ready=1 -> one rd_op, never an rd_op while fifo_empty=1, upstream rd_empty_err stays 0.
REQ-040 Random out_ready (50%) over 1000 words -> scoreboard order match, occ never >2, upstream err_rdempty never asserted.
REQ-041 Flush: sreset_n pulsed low for 1 clk with infl=1 and occ=1 -> next clk out_valid=0, busy=0, and the returning word never appears on out_data.
